// File: rtl/hazard_stall_controller.sv
// Purpose : detects load-use and ID-branch hazards that forwarding cannot cover; freezes PC/IF-ID,
//           injects ID/EX bubbles for a counted number of cycles, and flushes IF/ID after a taken branch.
// Latency : outputs are combinational from state and inputs (same-cycle reaction); stall length 1..2 cycles.
// Backpressure: the stall itself is the backpressure: PCWrite/IF_ID_Write low holds the front end in place.
//
// Ports:
//   Clk, Reset                 clock (rising edge), asynchronous active-high reset
//   ID_Rs/ID_Rt/ID_UsesRs/Rt   source registers of the ID instruction and whether they are read
//   ID_IsBranch/ID_BranchTaken branch compared in ID and its comparator result
//   EX_WriteReg/RegWrite/MemRead  destination, write enable and load flag of the EX instruction
//   PCWrite, IF_ID_Write       pipeline enables (0 = hold)
//   ID_EX_Bubble               zero ID/EX control this cycle
//   IF_ID_Flush                clear IF/ID on the next edge
//   Stalling                   FSM is in STALL
//   StallCycles, FlushCount    saturating event counters, present only when HAZARD_STATS_EN is defined
module hazard_stall_controller #(
  parameter int BR_LOAD_STALLS = 1,
  parameter int BR_ALU_STALLS  = 1,
  parameter int CNT_W          = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_IsBranch,
  input  logic        ID_BranchTaken,
  input  logic [4:0]  EX_WriteReg,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush,
  output logic        Stalling
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match;
  logic [CNT_W-1:0] need;
  logic             stall;

  // Register $0 is hard-wired, so writes to it never create a dependency.
  always_comb begin
    match = EX_RegWrite && (EX_WriteReg != 5'd0) &&
            ((ID_UsesRs && (EX_WriteReg == ID_Rs)) ||
             (ID_UsesRt && (EX_WriteReg == ID_Rt)));
  end

  // Number of bubbles the ID instruction needs before it may proceed.
  always_comb begin
    need = '0;
    if (match) begin
      if (ID_IsBranch) begin
        need = EX_MemRead ? CNT_W'(BR_LOAD_STALLS) : CNT_W'(BR_ALU_STALLS);
      end else if (EX_MemRead) begin
        need = CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    IF_ID_Flush = 1'b0;
    if (state_q == IDLE) begin
      if (need != '0) begin
        stall = 1'b1;
        // A single-cycle stall stays in IDLE so the hazard is re-evaluated next cycle.
        if (need > CNT_W'(1)) begin
          cnt_d   = need - CNT_W'(1);
          state_d = STALL;
        end
      end else if (ID_IsBranch && ID_BranchTaken) begin
        IF_ID_Flush = 1'b1;
      end
    end else begin
      // Hazard inputs are ignored here; the count alone decides the release.
      stall = 1'b1;
      if (cnt_q <= CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    PCWrite      = !stall;
    IF_ID_Write  = !stall;
    ID_EX_Bubble = stall;
    Stalling     = (state_q == STALL);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (ID_EX_Bubble && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (IF_ID_Flush && (flush_count_q != 32'hFFFF_FFFF))   flush_count_d  = flush_count_q + 32'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Purpose : directed self-checking bench for hazard_stall_controller (branch-load 1 stall, branch-ALU 2 stalls).
// Latency : outputs checked 2 time units after inputs change; state effects checked after each rising edge.
// Backpressure: n/a (bench drives every input directly).
module tb_hazard_stall_controller;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] ID_Rs, ID_Rt, EX_WriteReg;
  logic       ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchTaken;
  logic       EX_RegWrite, EX_MemRead;
  logic       PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling}
  localparam logic [4:0] O_NORM  = 5'b11000;
  localparam logic [4:0] O_STI   = 5'b00100;  // stall decided in IDLE
  localparam logic [4:0] O_STS   = 5'b00101;  // stall while in STALL
  localparam logic [4:0] O_FLUSH = 5'b11010;

  logic [4:0] outs;
  assign outs = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Stalling};

  hazard_stall_controller #(.BR_LOAD_STALLS(1), .BR_ALU_STALLS(2), .CNT_W(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_IsBranch(ID_IsBranch), .ID_BranchTaken(ID_BranchTaken),
    .EX_WriteReg(EX_WriteReg), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .Stalling(Stalling)
`ifdef HAZARD_STATS_EN
    , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic set_id(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic tk);
    ID_Rs = rs; ID_UsesRs = urs; ID_Rt = rt; ID_UsesRt = urt; ID_IsBranch = br; ID_BranchTaken = tk;
  endtask

  task automatic set_ex(input logic [4:0] wr, input logic rw, input logic mr);
    EX_WriteReg = wr; EX_RegWrite = rw; EX_MemRead = mr;
  endtask

  task automatic clear_all();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_ex(5'd0, 1'b0, 1'b0);
  endtask

  // Advance one clock; inputs are then changed 1 unit after the edge, outputs read 1 unit later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    Reset = 1'b1;
    #12;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_NORM); end
    @(negedge Clk);
    Reset = 1'b0;
    step();
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL post_reset_outs got=%b exp=%b", outs, O_NORM); end
  endtask

  task automatic test_load_use();
    set_ex(5'd8, 1'b1, 1'b1);
    set_id(5'd8, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL load_use_stall got=%b exp=%b", outs, O_STI); end
    step();
    // Same hazard still visible: single-cycle stalls re-evaluate from IDLE.
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL load_use_reeval got=%b exp=%b", outs, O_STI); end
    set_ex(5'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL load_use_release got=%b exp=%b", outs, O_NORM); end
    // Store data register (rt) dependency on a load.
    set_ex(5'd8, 1'b1, 1'b1);
    set_id(5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL load_use_rt got=%b exp=%b", outs, O_STI); end
    // rt matches but is not read.
    set_id(5'd2, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL rt_unused got=%b exp=%b", outs, O_NORM); end
    // ALU producer, non-branch consumer: forwarding covers it.
    set_ex(5'd8, 1'b1, 1'b0);
    set_id(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL alu_no_stall got=%b exp=%b", outs, O_NORM); end
    // Load that does not write the register file.
    set_ex(5'd8, 1'b0, 1'b1);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL no_regwrite got=%b exp=%b", outs, O_NORM); end
    clear_all();
    step();
  endtask

  task automatic test_branch_alu();
    set_ex(5'd9, 1'b1, 1'b0);
    set_id(5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);  // rs==rt, both match
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL br_alu_c0 got=%b exp=%b", outs, O_STI); end
    step();
    // EX now holds a bubble; STALL ignores inputs and keeps stalling.
    set_ex(5'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_STS) begin n_bad++; $display("FAIL br_alu_c1 got=%b exp=%b", outs, O_STS); end
    step();
    n_cmp++; if (outs !== O_FLUSH) begin n_bad++; $display("FAIL br_alu_release_flush got=%b exp=%b", outs, O_FLUSH); end
    clear_all();
    step();
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL br_alu_after got=%b exp=%b", outs, O_NORM); end
  endtask

  task automatic test_branch_load();
    set_ex(5'd10, 1'b1, 1'b1);
    set_id(5'd4, 1'b1, 5'd10, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL br_load_c0 got=%b exp=%b", outs, O_STI); end
    step();
    set_ex(5'd0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL br_load_release got=%b exp=%b", outs, O_NORM); end
    clear_all();
    step();
  endtask

  task automatic test_zero_reg();
    set_ex(5'd0, 1'b1, 1'b1);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL zero_reg_load got=%b exp=%b", outs, O_NORM); end
    set_ex(5'd0, 1'b1, 1'b0);
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1);
    #1;
    n_cmp++; if (outs !== O_FLUSH) begin n_bad++; $display("FAIL zero_reg_branch got=%b exp=%b", outs, O_FLUSH); end
    clear_all();
    step();
  endtask

  task automatic test_flush();
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1);
    set_ex(5'd7, 1'b1, 1'b0);
    #1;
    n_cmp++; if (outs !== O_FLUSH) begin n_bad++; $display("FAIL flush_taken got=%b exp=%b", outs, O_FLUSH); end
    step();
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL flush_not_taken got=%b exp=%b", outs, O_NORM); end
    // Taken branch with a load hazard: stall wins, no flush.
    set_id(5'd5, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1);
    set_ex(5'd6, 1'b1, 1'b1);
    #1;
    n_cmp++; if (outs !== O_STI) begin n_bad++; $display("FAIL flush_with_hazard got=%b exp=%b", outs, O_STI); end
    clear_all();
    step();
  endtask

  task automatic test_reset_mid_stall();
    set_ex(5'd12, 1'b1, 1'b0);
    set_id(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    clear_all();
    #1;
    n_cmp++; if (outs !== O_STS) begin n_bad++; $display("FAIL mid_stall_pre got=%b exp=%b", outs, O_STS); end
    #1;
    Reset = 1'b1;
    #1;
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL mid_stall_reset got=%b exp=%b", outs, O_NORM); end
    #1;
    Reset = 1'b0;
    step();
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL mid_stall_next got=%b exp=%b", outs, O_NORM); end
    // Counter restarts cleanly after the reset.
    set_ex(5'd12, 1'b1, 1'b0);
    set_id(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    clear_all();
    #1;
    n_cmp++; if (outs !== O_STS) begin n_bad++; $display("FAIL post_reset_stall got=%b exp=%b", outs, O_STS); end
    step();
    n_cmp++; if (outs !== O_NORM) begin n_bad++; $display("FAIL post_reset_release got=%b exp=%b", outs, O_NORM); end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    clear_all();
    Reset = 1'b1;
    #2;
    n_cmp++; if (StallCycles !== 32'd0) begin n_bad++; $display("FAIL stats_reset got=%0d exp=0", StallCycles); end
    Reset = 1'b0;
    step();
    set_ex(5'd8, 1'b1, 1'b1);
    set_id(5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
    set_ex(5'd9, 1'b1, 1'b0);
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
    step();
    clear_all();
    step();
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
    step();
    clear_all();
    step();
    n_cmp++; if (StallCycles !== 32'd3) begin n_bad++; $display("FAIL stats_stalls got=%0d exp=3", StallCycles); end
    n_cmp++; if (FlushCount !== 32'd1) begin n_bad++; $display("FAIL stats_flushes got=%0d exp=1", FlushCount); end
  endtask
`endif

  initial begin
    Reset = 1'b0;
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_zero_reg();
    test_flush();
    test_reset_mid_stall();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
